yarp_data_mem: RTL and testbench
================================

# yarp_data_mem

Load/store stage directly downstream of the execute ALU. Takes the ALU-computed effective address plus store data and load/store controls, runs a request/grant/response handshake with the data memory, and returns a lane-extracted, sign- or zero-extended load result to writeback. It stalls the core while a transfer is outstanding, flags misaligned accesses without touching the bus, and aborts on a response timeout.

## Interface
- TIMEOUT, 64: max cycles spent in REQ plus WAIT before abort; minimum 2.
- clk  in  1  core clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  1  access request; sampled only in IDLE.
- wr_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 00 = byte, 01 = half, 11 = word; 10 is treated as word.
- zero_extnd_i  in  1  load only: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  effective address (ALU result).
- wr_data_i  in  32  store data, right-aligned.
- busy_o  out  1  stall to the core; equals (state != IDLE).
- done_o  out  1  one-cycle pulse: access completed.
- rd_data_o  out  32  load result; valid while done_o is high, otherwise holds its last value.
- misalign_o  out  1  one-cycle pulse: misaligned request rejected.
- timeout_o  out  1  one-cycle pulse: access aborted on timeout.
- mem_req_o  out  1  memory request.
- mem_wr_o  out  1  memory write enable.
- mem_addr_o  out  32  word-aligned address, {addr[31:2], 2'b00}.
- mem_be_o  out  4  byte enables.
- mem_wr_data_o  out  32  lane-replicated store data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  read data valid.
- mem_rd_data_i  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT.
- Reset values: state = IDLE; every output is 0, including rd_data_o and all mem_* outputs.
- Alignment check (IDLE, req_i = 1):
  - half with addr[0] = 1, or word with addr[1:0] != 0 → misalign_o pulses next cycle.
  - No bus activity; state stays IDLE.
- Aligned request:
  - Latch addr, size, wr, zero_extnd and data, then go to REQ.
  - All mem_* outputs are registered and stay stable throughout REQ.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- REQ, mem_gnt_i = 1:
  - Store: complete; done_o pulses; return to IDLE.
  - Load with mem_rvalid_i = 1 in the same cycle: complete; go to IDLE.
  - Load otherwise: go to WAIT.
  - mem_req_o deasserts on the cycle after the grant.
- WAIT, mem_rvalid_i = 1: complete load; go to IDLE.
- Load result:
  - Shift mem_rd_data_i right by 8*addr[1:0].
  - Take the low 8/16/32 bits.
  - Extend per zero_extnd; register into rd_data_o alongside the done_o pulse.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT-1 with no completion event: timeout_o pulses, mem_req_o drops, state goes to IDLE, no done_o.
  - If completion and the limit land in the same cycle, completion wins.
- Ignored inputs:
  - req_i while busy_o = 1.
  - mem_rvalid_i and mem_gnt_i in IDLE, e.g. a stale response after an abort or reset.
- Reset mid-operation: IDLE and all outputs 0 on the next edge; the outstanding transfer is dropped.

## Timing
- done_o, misalign_o, timeout_o and rd_data_o are registered and go high exactly one cycle after the qualifying event.
- Zero-wait load, req_i at cycle N:
  - N+1: mem_req_o = 1; gnt and rvalid arrive.
  - N+2: done_o = 1 with rd_data_o valid; busy_o = 0.
- Store, req_i at cycle N, gnt at N+1: done_o at N+2.
- busy_o:
  - High from N+1 through the last REQ/WAIT cycle.
  - Low in the cycle done_o, misalign_o or timeout_o pulses, so back-to-back requests are accepted that cycle.
- Misaligned request at cycle N: misalign_o at N+1; busy_o never asserts.

## Test plan
- Load byte, addr 0x1003, mem_rd_data 0x80FF_1234, sign-extend, gnt+rvalid at N+1 → mem_be_o = 4'b1000, mem_addr_o = 0x1000, rd_data_o = 0xFFFF_FF80 with done_o at N+2; repeat with zero_extnd_i = 1 → 0x0000_0080.
- Store half, addr 0x2002, wr_data 0xDEAD_BEEF, gnt delayed 3 cycles → mem_be_o = 4'b1100 and mem_wr_data_o = 0xBEEF_BEEF held stable through REQ; done_o one cycle after the grant.
- Load word, gnt at N+1, rvalid 5 cycles later → state WAIT, busy_o high throughout, rd_data_o equals mem_rd_data_i, single done_o pulse.
- Word load at 0x0000_0006 → misalign_o pulses, mem_req_o never asserts, busy_o stays 0.
- TIMEOUT = 8, gnt never asserted → timeout_o pulses after 8 busy cycles, no done_o; an rvalid injected afterwards is ignored.
- Reset asserted while in WAIT → next cycle IDLE with all outputs 0; a subsequent load completes normally.

Source files
------------

// File: rtl/yarp_data_mem.sv
// Load/store stage: request/grant/response handshake with data memory, lane
// steering of store data, and extraction/extension of load results.
module yarp_data_mem #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic        zero_extnd_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rd_data_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_data_i
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d, size_q, size_d;
    logic          zext_q, zext_d;
    logic          done_q, done_d, mis_q, mis_d, to_q, to_d;
    logic [31:0]   rd_q, rd_d;
    logic          mreq_q, mreq_d, mwr_q, mwr_d;
    logic [31:0]   maddr_q, maddr_d, mwd_q, mwd_d;
    logic [3:0]    mbe_q, mbe_d;
    logic          misaligned;
    logic [31:0]   shifted, load_val;

    assign misaligned = (size_i == 2'b01 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);

    // Load lane extraction uses the latched offset/size, not the live inputs.
    always_comb begin
        shifted  = mem_rd_data_i >> {off_q, 3'b000};
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = zext_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = zext_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        off_d   = off_q;
        size_d  = size_q;
        zext_d  = zext_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        to_d    = 1'b0;
        rd_d    = rd_q;
        mreq_d  = mreq_q;
        mwr_d   = mwr_q;
        maddr_d = maddr_q;
        mbe_d   = mbe_q;
        mwd_d   = mwd_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_i && misaligned) begin
                    mis_d = 1'b1;
                end else if (req_i) begin
                    state_d = REQ;
                    off_d   = addr_i[1:0];
                    size_d  = size_i;
                    zext_d  = zero_extnd_i;
                    mreq_d  = 1'b1;
                    mwr_d   = wr_i;
                    maddr_d = {addr_i[31:2], 2'b00};
                    case (size_i)
                        2'b00: begin
                            mbe_d = 4'b0001 << addr_i[1:0];
                            mwd_d = {4{wr_data_i[7:0]}};
                        end
                        2'b01: begin
                            mbe_d = 4'b0011 << addr_i[1:0];
                            mwd_d = {2{wr_data_i[15:0]}};
                        end
                        default: begin
                            mbe_d = 4'b1111;
                            mwd_d = wr_data_i;
                        end
                    endcase
                end
            end
            REQ: begin
                // Completion is checked before the limit so it wins a tie.
                if (mem_gnt_i && (mwr_q || mem_rvalid_i)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    mreq_d  = 1'b0;
                    mwr_d   = 1'b0;
                    if (!mwr_q) rd_d = load_val;
                end else if (cnt_q == LIMIT) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    mreq_d  = 1'b0;
                    mwr_d   = 1'b0;
                end else if (mem_gnt_i) begin
                    state_d = WAIT;
                    mreq_d  = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rd_d    = load_val;
                end else if (cnt_q == LIMIT) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            zext_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            rd_q    <= '0;
            mreq_q  <= 1'b0;
            mwr_q   <= 1'b0;
            maddr_q <= '0;
            mbe_q   <= '0;
            mwd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            rd_q    <= rd_d;
            mreq_q  <= mreq_d;
            mwr_q   <= mwr_d;
            maddr_q <= maddr_d;
            mbe_q   <= mbe_d;
            mwd_q   <= mwd_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign rd_data_o     = rd_q;
    assign misalign_o    = mis_q;
    assign timeout_o     = to_q;
    assign mem_req_o     = mreq_q;
    assign mem_wr_o      = mwr_q;
    assign mem_addr_o    = maddr_q;
    assign mem_be_o      = mbe_q;
    assign mem_wr_data_o = mwd_q;
endmodule

// File: tb/tb_yarp_data_mem.sv
// Bench for yarp_data_mem: directed table, random accesses against a byte-level
// reference model, plus timeout and mid-transfer reset sequences.
module tb_yarp_data_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0, wr_i = 1'b0, zero_extnd_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] addr_i = '0, wr_data_i = '0;
    logic        busy_o, done_o, misalign_o, timeout_o, mem_req_o, mem_wr_o;
    logic [31:0] rd_data_o, mem_addr_o, mem_wr_data_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rd_data_i = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = '0;

    yarp_data_mem #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .wr_i(wr_i), .size_i(size_i),
        .zero_extnd_i(zero_extnd_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
        .busy_o(busy_o), .done_o(done_o), .rd_data_o(rd_data_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o), .mem_req_o(mem_req_o),
        .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        zx;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gd;
        int          rv;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: reason about individual byte lanes.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(a[1:0]) && i < int'(a[1:0]) + nbytes(sz)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic zx,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(int'(a[1:0]) + k) +: 8];
        if (!zx && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic chk_req(input string nm, input logic wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        chk({nm, ".req"}, {31'h0, mem_req_o}, 32'd1);
        chk({nm, ".busy"}, {31'h0, busy_o}, 32'd1);
        chk({nm, ".wr"}, {31'h0, mem_wr_o}, {31'h0, wr});
        chk({nm, ".addr"}, mem_addr_o, {a[31:2], 2'b00});
        chk({nm, ".be"}, {28'h0, mem_be_o}, {28'h0, be});
        chk({nm, ".wdata"}, mem_wr_data_o, wd);
    endtask

    task automatic do_access(input string nm, input vec_t v);
        req_i = 1'b1; wr_i = v.wr; size_i = v.sz; zero_extnd_i = v.zx;
        addr_i = v.addr; wr_data_i = v.wd;
        tick();
        req_i = 1'b0;
        if (v.mis) begin
            chk({nm, ".mis"}, {31'h0, misalign_o}, 32'd1);
            chk({nm, ".mbusy"}, {31'h0, busy_o}, 32'd0);
            chk({nm, ".mreq"}, {31'h0, mem_req_o}, 32'd0);
            tick();
            chk({nm, ".mis_end"}, {31'h0, misalign_o}, 32'd0);
            chk({nm, ".mreq2"}, {31'h0, mem_req_o}, 32'd0);
        end else begin
            for (int i = 0; i < v.gd; i++) begin
                chk_req(nm, v.wr, v.addr, v.be, v.ewd);
                mem_rd_data_i = $urandom;
                tick();
            end
            chk_req(nm, v.wr, v.addr, v.be, v.ewd);
            mem_gnt_i = 1'b1;
            if (!v.wr && v.rv == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rd_data_i = v.rd;
            end
            tick();
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rd_data_i = $urandom;
            if (!v.wr && v.rv > 0) begin
                chk({nm, ".wreq"}, {31'h0, mem_req_o}, 32'd0);
                for (int i = 0; i < v.rv - 1; i++) begin
                    chk({nm, ".wbusy"}, {31'h0, busy_o}, 32'd1);
                    chk({nm, ".wdone"}, {31'h0, done_o}, 32'd0);
                    tick();
                end
                mem_rvalid_i = 1'b1;
                mem_rd_data_i = v.rd;
                tick();
                mem_rvalid_i = 1'b0;
            end
            chk({nm, ".done"}, {31'h0, done_o}, 32'd1);
            chk({nm, ".dbusy"}, {31'h0, busy_o}, 32'd0);
            chk({nm, ".dreq"}, {31'h0, mem_req_o}, 32'd0);
            if (!v.wr) last_rd = v.erd;
            chk({nm, ".rdata"}, rd_data_o, last_rd);
            tick();
            chk({nm, ".done_end"}, {31'h0, done_o}, 32'd0);
            chk({nm, ".rhold"}, rd_data_o, last_rd);
        end
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
        tbl[1] = '{1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
        tbl[2] = '{1'b1, 2'b01, 1'b0, 32'h2002, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[3] = '{1'b0, 2'b11, 1'b0, 32'h3000, 32'h0, 32'h1234_5678, 0, 5, 1'b0, 4'b1111, 32'h0, 32'h1234_5678};
        tbl[4] = '{1'b0, 2'b11, 1'b0, 32'h0006, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 2'b01, 1'b0, 32'h4002, 32'h0, 32'h9ABC_0000, 1, 1, 1'b0, 4'b1100, 32'h0, 32'hFFFF_9ABC};
        tbl[6] = '{1'b0, 2'b10, 1'b1, 32'h0010, 32'h0, 32'hCAFE_F00D, 0, 2, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D};
        tbl[7] = '{1'b1, 2'b00, 1'b0, 32'h0021, 32'h1234_56A5, 32'h0, 1, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        tbl[8] = '{1'b0, 2'b01, 1'b0, 32'h0005, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
        tbl[9] = '{1'b0, 2'b11, 1'b0, 32'h0040, 32'h0, 32'h0BAD_F00D, 3, 4, 1'b0, 4'b1111, 32'h0, 32'h0BAD_F00D};

        tick(); tick();
        chk("rst.busy", {31'h0, busy_o}, 32'd0);
        chk("rst.done", {31'h0, done_o}, 32'd0);
        chk("rst.rdata", rd_data_o, 32'h0);
        chk("rst.flags", {29'h0, misalign_o, timeout_o, mem_wr_o}, 32'd0);
        chk("rst.req", {31'h0, mem_req_o}, 32'd0);
        chk("rst.bus", mem_addr_o | mem_wr_data_o | {28'h0, mem_be_o}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) do_access($sformatf("vec%0d", i), tbl[i]);

        // Abort: grant never comes; eight busy cycles, then a timeout pulse.
        req_i = 1'b1; wr_i = 1'b0; size_i = 2'b11; addr_i = 32'h100;
        tick();
        req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to.busy", {31'h0, busy_o}, 32'd1);
            chk("to.early", {31'h0, timeout_o}, 32'd0);
            tick();
        end
        chk("to.pulse", {31'h0, timeout_o}, 32'd1);
        chk("to.idle", {31'h0, busy_o}, 32'd0);
        chk("to.nodone", {31'h0, done_o}, 32'd0);
        chk("to.req", {31'h0, mem_req_o}, 32'd0);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rd_data_i = 32'h5555_AAAA;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("to.stale_done", {31'h0, done_o}, 32'd0);
        chk("to.stale_busy", {31'h0, busy_o}, 32'd0);
        chk("to.stale_rd", rd_data_o, last_rd);
        chk("to.pulse_end", {31'h0, timeout_o}, 32'd0);

        // Reset while waiting for read data.
        req_i = 1'b1; wr_i = 1'b0; size_i = 2'b11; addr_i = 32'h80;
        tick();
        req_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("rw.wait", {31'h0, busy_o}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw.busy", {31'h0, busy_o}, 32'd0);
        chk("rw.rdata", rd_data_o, 32'h0);
        chk("rw.req", {31'h0, mem_req_o}, 32'd0);
        chk("rw.bus", mem_addr_o | mem_wr_data_o | {28'h0, mem_be_o}, 32'h0);
        last_rd = '0;
        do_access("rw.after", '{1'b0, 2'b11, 1'b0, 32'h84, 32'h0, 32'h7777_1111, 0, 0,
                                1'b0, 4'b1111, 32'h0, 32'h7777_1111});

        for (int n = 0; n < 80; n++) begin
            vec_t v;
            v.wr   = 1'($urandom_range(0, 1));
            v.sz   = 2'($urandom_range(0, 3));
            v.zx   = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            v.wd   = $urandom;
            v.rd   = $urandom;
            v.gd   = $urandom_range(0, 3);
            v.rv   = $urandom_range(0, 3);
            v.mis  = m_mis(v.sz, v.addr);
            v.be   = m_be(v.sz, v.addr);
            v.ewd  = m_wd(v.sz, v.wd);
            v.erd  = m_ld(v.sz, v.zx, v.addr, v.rd);
            do_access($sformatf("rnd%0d", n), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
